// File: rtl/pi_loop_sequencer_if.sv
// Stage handshake between the loop sequencer and the ADC / PI / DAC chain.
// The sequencer drives the start pulses; the chain returns done and busy status.
interface pi_loop_sequencer_if;
  logic adc_start;
  logic adc_done;
  logic pi_start;
  logic pi_done;
  logic dac_start;
  logic dac_busy;

  modport master (
    output adc_start, pi_start, dac_start,
    input  adc_done, pi_done, dac_busy
  );

  modport slave (
    input  adc_start, pi_start, dac_start,
    output adc_done, pi_done, dac_busy
  );
endinterface

// File: rtl/pi_loop_sequencer.sv
// Sample-rate scheduler for the PI loop: fixed sampling period, one
// ADC -> PI -> DAC iteration per period, with overrun and stage-timeout flags.
module pi_loop_sequencer #(
  parameter int unsigned SAMPLE_DIV = 83333,
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned STAGE_TO   = 4096,
  parameter int unsigned TO_W       = 13
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                enable,
  input  logic                clr_status,
  pi_loop_sequencer_if.master loop_bus,
  output logic                sample_tick,
  output logic                overrun,
  output logic                timeout,
  output logic [15:0]         sample_count,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    ADC       = 3'd2,
    PI        = 3'd3,
    DAC_WAIT  = 3'd4,
    DAC       = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(STAGE_TO - 1);

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] per_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             expired;
  logic             to_set;
  logic             ov_set;

  always_comb begin
    nxt_state = cur_state;
    to_set    = 1'b0;
    expired   = (to_cnt == TO_LAST);
    // Completion is tested before expiry so a done on the last cycle still counts.
    case (cur_state)
      IDLE:      if (enable) nxt_state = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable)          nxt_state = IDLE;
        else if (sample_tick) nxt_state = ADC;
      end
      ADC: begin
        if (loop_bus.adc_done) nxt_state = PI;
        else if (expired) begin
          nxt_state = WAIT_TICK;
          to_set    = 1'b1;
        end
      end
      PI: begin
        if (loop_bus.pi_done) nxt_state = DAC_WAIT;
        else if (expired) begin
          nxt_state = WAIT_TICK;
          to_set    = 1'b1;
        end
      end
      DAC_WAIT: begin
        if (!loop_bus.dac_busy) nxt_state = DAC;
        else if (expired) begin
          nxt_state = WAIT_TICK;
          to_set    = 1'b1;
        end
      end
      DAC:       nxt_state = WAIT_TICK;
      default:   nxt_state = IDLE;
    endcase
    ov_set = sample_tick && (cur_state inside {ADC, PI, DAC_WAIT, DAC});
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cur_state          <= IDLE;
      per_cnt            <= '0;
      to_cnt             <= '0;
      sample_tick        <= 1'b0;
      overrun            <= 1'b0;
      timeout            <= 1'b0;
      sample_count       <= '0;
      loop_bus.adc_start <= 1'b0;
      loop_bus.pi_start  <= 1'b0;
      loop_bus.dac_start <= 1'b0;
    end else begin
      cur_state <= nxt_state;

      if (cur_state == IDLE)      per_cnt <= '0;
      else if (per_cnt == PER_LAST) per_cnt <= '0;
      else                        per_cnt <= per_cnt + 1'b1;
      sample_tick <= (cur_state != IDLE) && (per_cnt == PER_LAST);

      if (nxt_state != cur_state) to_cnt <= '0;
      else if (cur_state inside {ADC, PI, DAC_WAIT}) to_cnt <= to_cnt + 1'b1;

      loop_bus.adc_start <= (nxt_state == ADC) && (cur_state != ADC);
      loop_bus.pi_start  <= (nxt_state == PI)  && (cur_state != PI);
      loop_bus.dac_start <= (nxt_state == DAC) && (cur_state != DAC);

      if (cur_state == DAC) sample_count <= sample_count + 16'd1;

      overrun <= ov_set | (overrun & ~clr_status);
      timeout <= to_set | (timeout & ~clr_status);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// Randomized scoreboard bench: an iteration-level timing model predicts every
// pulse and flag edge; a monitor matches what the sequencer actually emits.
module tb_pi_loop_sequencer;
  localparam int PERIOD = 20;
  localparam int STO    = 16;
  localparam int K_TICK = 0, K_ADC = 1, K_PI = 2, K_DAC = 3;
  localparam int K_OVR_R = 4, K_OVR_F = 5, K_TO_R = 6, K_TO_F = 7, K_CNT = 8;
  localparam int NO_CUT = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        enable = 1'b0;
  logic        clr_status = 1'b0;
  logic        sample_tick, overrun, timeout;
  logic [15:0] sample_count;
  logic [2:0]  state;

  pi_loop_sequencer_if bus();

  pi_loop_sequencer #(
    .SAMPLE_DIV(PERIOD),
    .CNT_W(5),
    .STAGE_TO(STO),
    .TO_W(5)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .enable(enable),
    .clr_status(clr_status),
    .loop_bus(bus.master),
    .sample_tick(sample_tick),
    .overrun(overrun),
    .timeout(timeout),
    .sample_count(sample_count),
    .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int sb[$];
  int lat_a[$], lat_b[$], lat_c[$];
  int m_it = 0, m_count = 0;
  bit m_ovr = 0, m_to = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void sb_push(input int c, input int k, input int cut);
    int key;
    int i;
    if (c >= cut) return;
    key = c * 16 + k;
    i = sb.size();
    while (i > 0 && sb[i-1] > key) i--;
    sb.insert(i, key);
  endfunction

  function automatic void push_lat(input int a, input int b, input int c);
    lat_a.push_back(a);
    lat_b.push_back(b);
    lat_c.push_back(c);
  endfunction

  // Timeline of one enable window: enable high in cycle e, low from cycle d,
  // optional clr_status in cycle clr_cyc; events at or after cut are not expected.
  task automatic model_phase(input int e, input int d, input int clr_cyc,
                             input int cut, output int idle);
    int  s, w, t, p, q, nt, a, b, c;
    bit  o_set[int];
    bit  t_set[int];
    bit  f;
    s = e + 1;
    w = s;
    forever begin
      if (w == s) nt = s + PERIOD;
      else        nt = s + PERIOD * ((w - s + PERIOD - 1) / PERIOD);
      if (nt >= d) begin
        idle = ((w > d) ? w : d) + 1;
        break;
      end
      t = nt;
      a = lat_a[m_it]; b = lat_b[m_it]; c = lat_c[m_it];
      m_it++;
      sb_push(t + 1, K_ADC, cut);
      if (a >= STO) begin
        t_set[t + STO] = 1;
        w = t + STO + 1;
      end else begin
        p = t + 2 + a;
        sb_push(p, K_PI, cut);
        if (b >= STO) begin
          t_set[p + STO - 1] = 1;
          w = p + STO;
        end else begin
          q = p + b + 1;
          if (c >= STO) begin
            t_set[q + STO - 1] = 1;
            w = q + STO;
          end else begin
            sb_push(q + 1 + c, K_DAC, cut);
            sb_push(q + 2 + c, K_CNT, cut);
            if (q + 2 + c < cut) m_count++;
            w = q + 2 + c;
          end
        end
      end
      for (int g = t + PERIOD; g < w; g += PERIOD) o_set[g] = 1;
    end
    for (int g = s + PERIOD; g <= idle; g += PERIOD) sb_push(g, K_TICK, cut);
    for (int n = s; n <= idle; n++) begin
      f = o_set.exists(n) || (m_ovr && n != clr_cyc);
      if (f != m_ovr) sb_push(n + 1, f ? K_OVR_R : K_OVR_F, cut);
      m_ovr = f;
      f = t_set.exists(n) || (m_to && n != clr_cyc);
      if (f != m_to) sb_push(n + 1, f ? K_TO_R : K_TO_F, cut);
      m_to = f;
    end
  endtask

  // Chain responder: latencies are taken per iteration in adc_start order.
  initial begin
    int adc_cd, pi_cd, busy_cd, r_it, r_idx;
    adc_cd = 0; pi_cd = 0; busy_cd = 0; r_it = 0; r_idx = 0;
    bus.adc_done = 1'b0;
    bus.pi_done  = 1'b0;
    bus.dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      bus.adc_done = 1'b0;
      if (adc_cd > 0) begin adc_cd--; if (adc_cd == 0) bus.adc_done = 1'b1; end
      bus.pi_done = 1'b0;
      if (pi_cd > 0) begin pi_cd--; if (pi_cd == 0) bus.pi_done = 1'b1; end
      if (busy_cd > 0) begin bus.dac_busy = 1'b1; busy_cd--; end
      else bus.dac_busy = 1'b0;
      if (bus.pi_done) busy_cd = (r_idx < lat_c.size()) ? lat_c[r_idx] : 0;
      if (bus.adc_start === 1'b1) begin
        r_idx = r_it;
        r_it++;
        adc_cd = (r_idx < lat_a.size()) ? lat_a[r_idx] : 1;
      end
      if (bus.pi_start === 1'b1) pi_cd = (r_idx < lat_b.size()) ? lat_b[r_idx] : 1;
    end
  end

  // Monitor: every observed pulse or flag/count edge must match the next expected event.
  initial begin
    bit   ev [9];
    logic p_ovr, p_to;
    logic [15:0] p_cnt;
    int   exp_key;
    p_ovr = 1'b0; p_to = 1'b0; p_cnt = '0;
    forever begin
      @(negedge clk);
      ev[K_TICK]  = (sample_tick === 1'b1);
      ev[K_ADC]   = (bus.adc_start === 1'b1);
      ev[K_PI]    = (bus.pi_start === 1'b1);
      ev[K_DAC]   = (bus.dac_start === 1'b1);
      ev[K_OVR_R] = (overrun === 1'b1) && (p_ovr !== 1'b1);
      ev[K_OVR_F] = (overrun !== 1'b1) && (p_ovr === 1'b1);
      ev[K_TO_R]  = (timeout === 1'b1) && (p_to !== 1'b1);
      ev[K_TO_F]  = (timeout !== 1'b1) && (p_to === 1'b1);
      ev[K_CNT]   = (sample_count !== p_cnt);
      if (mon_en) begin
        for (int k = 0; k < 9; k++) begin
          if (ev[k]) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL event: got cycle %0d kind %0d, expected none", cyc, k);
            end else begin
              exp_key = sb.pop_front();
              if (exp_key != cyc * 16 + k) begin
                errors++;
                $display("FAIL event: got cycle %0d kind %0d, expected cycle %0d kind %0d",
                         cyc, k, exp_key / 16, exp_key % 16);
              end
            end
          end
        end
      end
      p_ovr = overrun; p_to = timeout; p_cnt = sample_count;
    end
  end

  task automatic flush_check(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_phase(input int d_off, input int clr_off);
    int e, s, d, cc, idle;
    e  = cyc;
    s  = e + 1;
    d  = s + d_off;
    cc = (clr_off < 0) ? -1 : s + clr_off;
    model_phase(e, d, cc, NO_CUT, idle);
    enable = 1'b1;
    while (cyc < idle + 6) begin
      @(negedge clk);
      if (cyc == d) enable = 1'b0;
      clr_status = (cyc == cc);
    end
    clr_status = 1'b0;
    flush_check("phase_events_drained");
    chk("phase_idle_state", state, 0);
    chk("phase_sample_count", sample_count, m_count & 32'hFFFF);
  endtask

  task automatic do_clear();
    clr_status = 1'b1;
    if (m_ovr) sb_push(cyc + 1, K_OVR_F, NO_CUT);
    if (m_to)  sb_push(cyc + 1, K_TO_F, NO_CUT);
    m_ovr = 0;
    m_to  = 0;
    @(negedge clk);
    clr_status = 1'b0;
    @(negedge clk);
    flush_check("clear_events_drained");
  endtask

  function automatic int rand_lat(input int lo);
    if ($urandom_range(0, 3) == 0) return $urandom_range(10, 18);
    return $urandom_range(lo, 6);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_adc_start"}, bus.adc_start, 0);
    chk({tag, "_pi_start"}, bus.pi_start, 0);
    chk({tag, "_dac_start"}, bus.dac_start, 0);
    chk({tag, "_sample_tick"}, sample_tick, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_sample_count"}, sample_count, 0);
  endtask

  initial begin
    int k, t, r, e, s, idle;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_b = 1'b1;
    mon_en  = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal loop: two clean iterations.
    push_lat(3, 2, 0); push_lat(3, 2, 0);
    run_phase(50, -1);
    // ADC stall times out, next tick runs a clean iteration.
    push_lat(17, 2, 0); push_lat(3, 2, 0);
    run_phase(45, -1);
    // DAC back-pressure: short stall, then a stall long enough to time out.
    push_lat(3, 2, 5); push_lat(3, 2, 20);
    run_phase(45, -1);
    do_clear();
    // Slow iteration overlaps the next tick while clr_status is pulsed on that tick.
    push_lat(9, 9, 0);
    run_phase(45, 40);
    do_clear();

    for (int ph = 0; ph < 8; ph++) begin
      k = $urandom_range(1, 4);
      for (int i = 0; i <= k; i++) push_lat(rand_lat(1), rand_lat(1), rand_lat(0));
      t = PERIOD * k + $urandom_range(1, PERIOD - 1);
      run_phase(t, ($urandom_range(0, 2) == 0) ? $urandom_range(PERIOD, t) : -1);
      if ($urandom_range(0, 1) == 0) do_clear();
    end

    // Asynchronous reset while the PI stage is waiting.
    push_lat(3, 10, 0);
    e = cyc; s = e + 1; t = s + PERIOD; r = t + 8;
    model_phase(e, t + 1, -1, r, idle);
    enable = 1'b1;
    while (cyc < r - 1) begin
      @(negedge clk);
      if (cyc == t + 1) enable = 1'b0;
    end
    chk("pre_reset_state_pi", state, 3);
    @(posedge clk);
    #2;
    mon_en  = 1'b0;
    reset_b = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_ovr = 0; m_to = 0; m_count = 0;
    flush_check("reset_events_drained");
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    mon_en  = 1'b1;
    push_lat(4, 3, 2);
    run_phase(30, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
